// File: rtl/gcd_req_arbiter.sv
// Two-requester arbiter in front of a single shared GCD unit, with at most one request outstanding.
// Define GCD_REQ_ARBITER_RR_EN for round-robin arbitration; the default build uses fixed priority, requester 0 first.
module gcd_req_arbiter (
    input  logic        clk,
    input  logic        reset,

    input  logic        in0_val,
    output logic        in0_rdy,
    input  logic [31:0] in0_msg,

    input  logic        in1_val,
    output logic        in1_rdy,
    input  logic [31:0] in1_msg,

    output logic        out0_val,
    input  logic        out0_rdy,
    output logic [15:0] out0_msg,

    output logic        out1_val,
    input  logic        out1_rdy,
    output logic [15:0] out1_msg,

    output logic        gcd_req_val,
    input  logic        gcd_req_rdy,
    output logic [31:0] gcd_req_msg,

    input  logic        gcd_resp_val,
    output logic        gcd_resp_rdy,
    input  logic [15:0] gcd_resp_msg,

    output logic        owner,
    output logic        busy
);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_WAIT = 1'b1;

    logic r_state;
    logic w_state_nxt;
    logic r_owner;
    logic w_owner_nxt;
    logic w_any;
    logic w_grant;

`ifdef GCD_REQ_ARBITER_RR_EN
    logic r_ptr;
    logic w_ptr_nxt;

    // A lone requester wins outright; on contention the pointer picks the winner.
    always_comb begin
        w_any   = in0_val | in1_val;
        w_grant = (in0_val && in1_val) ? r_ptr : ~in0_val;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= 1'b0;
        end else begin
            r_ptr <= w_ptr_nxt;
        end
    end
`else
    // Requester 0 always wins on contention.
    always_comb begin
        w_any   = in0_val | in1_val;
        w_grant = ~in0_val;
    end
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_owner <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
        end
    end

    // Next state and handshake routing; everything is forced quiet while reset is high.
    always_comb begin
        w_state_nxt  = r_state;
        w_owner_nxt  = r_owner;
`ifdef GCD_REQ_ARBITER_RR_EN
        w_ptr_nxt    = r_ptr;
`endif
        in0_rdy      = 1'b0;
        in1_rdy      = 1'b0;
        gcd_req_val  = 1'b0;
        gcd_req_msg  = w_grant ? in1_msg : in0_msg;
        gcd_resp_rdy = 1'b0;
        out0_val     = 1'b0;
        out1_val     = 1'b0;
        out0_msg     = gcd_resp_msg;
        out1_msg     = gcd_resp_msg;

        if (!reset) begin
            if (r_state == ST_IDLE) begin
                if (w_any) begin
                    gcd_req_val = 1'b1;
                    if (w_grant) begin
                        in1_rdy = gcd_req_rdy;
                    end else begin
                        in0_rdy = gcd_req_rdy;
                    end
                    if (gcd_req_rdy) begin
                        w_state_nxt = ST_WAIT;
                        w_owner_nxt = w_grant;
`ifdef GCD_REQ_ARBITER_RR_EN
                        w_ptr_nxt   = ~w_grant;
`endif
                    end
                end
            end else begin
                if (r_owner) begin
                    out1_val     = gcd_resp_val;
                    gcd_resp_rdy = out1_rdy;
                end else begin
                    out0_val     = gcd_resp_val;
                    gcd_resp_rdy = out0_rdy;
                end
                if (gcd_resp_val && gcd_resp_rdy) begin
                    w_state_nxt = ST_IDLE;
                end
            end
        end
    end

    assign owner = r_owner;
    assign busy  = (r_state == ST_WAIT) && !reset;

endmodule

// File: doc/gcd_req_arbiter.md
GCD_REQ_ARBITER -- requirements
Module: gcd_req_arbiter

Interface
REQ-001 SHALL have ports: clk  input  1  clock; all state updates on rising edge.
REQ-002 SHALL have ports: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have ports: in0_val input 1, in0_rdy output 1, in0_msg input 32  requester 0 request; msg[31:16]=A, msg[15:0]=B.
REQ-004 SHALL have ports: in1_val input 1, in1_rdy output 1, in1_msg input 32  requester 1 request, same format.
REQ-005 SHALL have ports: out0_val output 1, out0_rdy input 1, out0_msg output 16  requester 0 response.
REQ-006 SHALL have ports: out1_val output 1, out1_rdy input 1, out1_msg output 16  requester 1 response.
REQ-007 SHALL have ports: gcd_req_val output 1, gcd_req_rdy input 1, gcd_req_msg output 32  request to the shared GCD unit.
REQ-008 SHALL have ports: gcd_resp_val input 1, gcd_resp_rdy output 1, gcd_resp_msg input 16  response from the shared GCD unit.
REQ-009 SHALL have ports: owner output 1  index of requester currently owning the GCD unit; valid in state WAIT.
REQ-010 SHALL have ports: busy output 1  high in state WAIT.
REQ-011 SHALL use reset reset, synchronous, active-high; clock clk.

Function
REQ-012 SHALL implement a two-state FSM: IDLE (arbitrate, forward request) and WAIT (route response); at most one request outstanding at the GCD unit.
REQ-013 In IDLE, grant g SHALL be computed combinationally from in0_val/in1_val and the priority policy (REQ-027/028); no valid requester means no grant.
REQ-014 In IDLE with grant g: gcd_req_val=1, gcd_req_msg=in<g>_msg, in<g>_rdy=gcd_req_rdy, the other in*_rdy=0; zero added latency.
REQ-015 In IDLE with no grant: gcd_req_val=0, both in*_rdy=0; gcd_req_msg is don't-care.
REQ-016 Request transfer (gcd_req_val && gcd_req_rdy) in IDLE SHALL latch owner<=g and move to WAIT at next edge.
REQ-017 In WAIT: in0_rdy=in1_rdy=0, gcd_req_val=0; new requests stall until return to IDLE.
REQ-018 In WAIT: out<owner>_val=gcd_resp_val, out<owner>_msg=gcd_resp_msg, gcd_resp_rdy=out<owner>_rdy; the non-owner out*_val=0.
REQ-019 Response transfer (gcd_resp_val && gcd_resp_rdy) in WAIT SHALL return FSM to IDLE at next edge; back-to-back requests thus take min 2 cycles between acceptances.
REQ-020 In IDLE gcd_resp_rdy=0 and both out*_val=0; a spurious gcd_resp_val in IDLE SHALL be ignored.
REQ-021 out*_msg SHALL equal gcd_resp_msg whenever out*_val=1; value otherwise don't-care.
REQ-022 Downstream back-pressure (out<owner>_rdy=0) SHALL hold WAIT indefinitely, with gcd_resp_rdy=0 and no state change.
REQ-023 Request and response data SHALL pass through unmodified; no width conversion or arithmetic.

Reset
REQ-024 While reset=1: FSM<=IDLE, owner<=0, priority pointer<=0 (requester 0 favoured first).
REQ-025 While reset=1 all val/rdy outputs (in*_rdy, out*_val, gcd_req_val, gcd_resp_rdy) and busy SHALL be 0.
REQ-026 Reset asserted in WAIT SHALL abandon the outstanding request; the GCD unit is reset in the same cycle by the integrator, and no response is delivered.

Configuration
REQ-027 With GCD_REQ_ARBITER_RR_EN defined: round-robin; pointer names the favoured requester; on each accepted request pointer<=~g; if only one requester valid, it is granted regardless of pointer.
REQ-028 Without GCD_REQ_ARBITER_RR_EN: fixed priority, requester 0 always wins when both valid; pointer register is not implemented.

Verification
REQ-029 Single request: in0 msg 0x000F_0005, GCD unit attached, out0_rdy=1 -> out0_val with msg 0x0005, out1_val never asserted, owner=0 during WAIT.
REQ-030 Simultaneous: in0=0x0030_0012, in1=0x0015_000E both valid from reset -> in0 granted first (0x0006 on out0), then in1 (0x0007 on out1), both modes.
REQ-031 Fairness (RR_EN defined): both requesters continuously valid for 6 requests -> grants alternate 0,1,0,1,0,1; without RR_EN all 6 go to requester 0 until in0_val drops.
REQ-032 Back-pressure: out1_rdy=0 for 10 cycles with response pending -> busy stays 1, gcd_resp_rdy=0, in0_rdy=0 despite in0_val=1; releases in the cycle out1_rdy rises.
REQ-033 Reset mid-operation: assert reset in WAIT for 1 cycle -> next cycle IDLE, owner=0, no out*_val; a fresh in1 request 0x0009_0003 then returns 0x0003 on out1.
REQ-034 Stall on downstream: gcd_req_rdy=0 with in1_val=1 -> in1_rdy=0, gcd_req_val=1, gcd_req_msg=in1_msg stable, FSM stays IDLE.
